// File: rtl/piano_frame_scanner.sv
// Renders the 77x60 piano keyboard image into the framebuffer by walking every
// pixel, answering key queries from a frozen key snapshot, and writing each colour.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   keys_down        live pressed-key mask (bit i = key i)
//   start            level-sampled redraw request
//   gfx_x, gfx_y     current pixel coordinate driven to the pixel generator
//   key_requested    key index queried by the pixel generator
//   is_key_playing   snapshot bit for key_requested (0 when out of range)
//   gfx_color        pixel colour returned by the pixel generator
//   fb_we/fb_addr/fb_data, fb_ready   valid/ready framebuffer write port
//   busy             high from SCAN entry through the DONE cycle
//   frame_done       one-cycle pulse after the last pixel is accepted
module piano_frame_scanner #(
    parameter int WIDTH    = 77,
    parameter int HEIGHT   = 60,
    parameter int NUM_KEYS = 12,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       keys_down,
    input  logic              start,
    output logic [6:0]        gfx_x,
    output logic [5:0]        gfx_y,
    input  logic [4:0]        key_requested,
    output logic              is_key_playing,
    input  logic [2:0]        gfx_color,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [NUM_KEYS-1:0] snapshot;
    logic                pending;
    logic [ADDR_W-1:0]   addr;
    logic [NUM_KEYS-1:0] key_shift;

    logic trigger;
    logic x_last;
    logic y_last;
    logic accept;

    assign trigger = pending | start | (keys_down != snapshot);
    assign x_last  = (gfx_x == 7'(WIDTH - 1));
    assign y_last  = (gfx_y == 6'(HEIGHT - 1));
    assign accept  = fb_we & fb_ready;

    // Shift instead of a variable index so an out-of-range key never
    // selects past the top of the mask.
    assign key_shift = snapshot >> key_requested;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                state_nx = WRITE;
            end
            WRITE: begin
                if (accept) begin
                    state_nx = (x_last && y_last) ? DONE : SCAN;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy           = (state != IDLE);
        frame_done     = (state == DONE);
        is_key_playing = 1'b0;
        if (key_requested < 5'(NUM_KEYS)) begin
            is_key_playing = key_shift[0];
        end
    end

    // Datapath: coordinates, address counter, snapshot and write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gfx_x    <= '0;
            gfx_y    <= '0;
            addr     <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            snapshot <= '0;
            pending  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        snapshot <= keys_down;
                        pending  <= 1'b0;
                        gfx_x    <= '0;
                        gfx_y    <= '0;
                        addr     <= '0;
                    end
                end
                SCAN: begin
                    if (start) begin
                        pending <= 1'b1;
                    end
                    fb_data <= gfx_color;
                    fb_addr <= addr;
                    fb_we   <= 1'b1;
                end
                WRITE: begin
                    if (start) begin
                        pending <= 1'b1;
                    end
                    if (accept) begin
                        fb_we <= 1'b0;
                        addr  <= addr + ADDR_W'(1);
                        if (!(x_last && y_last)) begin
                            if (x_last) begin
                                gfx_x <= '0;
                                gfx_y <= gfx_y + 6'd1;
                            end else begin
                                gfx_x <= gfx_x + 7'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    pending <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piano_frame_scanner.sv
// Self-checking bench for piano_frame_scanner with a behavioural pixel generator
// and a frame-level reference model (address order and colour per pixel).
module tb_piano_frame_scanner;

    localparam int W   = 77;
    localparam int H   = 60;
    localparam int NPX = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] keys_down;
    logic        start;
    logic [6:0]  gfx_x;
    logic [5:0]  gfx_y;
    logic [4:0]  key_requested;
    logic        is_key_playing;
    logic [2:0]  gfx_color;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ready;
    logic        busy;
    logic        frame_done;

    piano_frame_scanner dut (
        .clk            (clk),
        .rst            (rst),
        .keys_down      (keys_down),
        .start          (start),
        .gfx_x          (gfx_x),
        .gfx_y          (gfx_y),
        .key_requested  (key_requested),
        .is_key_playing (is_key_playing),
        .gfx_color      (gfx_color),
        .fb_we          (fb_we),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .fb_ready       (fb_ready),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Keyboard rules: top rows query key x/7, bottom rows query out-of-range keys.
    function automatic int key_of(int x, int y);
        return (y >= 55) ? (12 + x % 20) : (x / 7);
    endfunction

    function automatic bit is_black(int k);
        return (k == 1 || k == 3 || k == 6 || k == 8 || k == 10);
    endfunction

    function automatic int color_of(int k, bit playing);
        if (playing) return 4;
        return is_black(k) ? 0 : 7;
    endfunction

    function automatic int exp_color(int x, int y, logic [11:0] mask);
        int k;
        bit p;
        k = key_of(x, y);
        p = (k < 12) ? mask[k] : 1'b0;
        return color_of(k, p);
    endfunction

    // Behavioural pixel generator driven by the DUT's coordinates.
    always_comb begin
        key_requested = 5'(key_of(int'(gfx_x), int'(gfx_y)));
        gfx_color = 3'(color_of(int'(key_requested), is_key_playing));
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t         wq[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          first_we_cyc = -1;
    int          stall_bad = 0;
    bit          prev_stall = 0;
    logic [12:0] prev_addr;
    logic [2:0]  prev_data;
    bit          rdy_rand = 0;

    // Write monitor: collects accepted writes and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall &&
                (!fb_we || fb_addr !== prev_addr || fb_data !== prev_data))
                stall_bad++;
            if (fb_we && fb_ready)
                wq.push_back('{int'(fb_addr), int'(fb_data)});
            if (fb_we && first_we_cyc < 0)
                first_we_cyc = cyc;
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fb_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(string tag, int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done_cnt - d0, 1);
    endtask

    task automatic wait_pixels(string tag, int npix, int budget);
        int n;
        n = 0;
        while (wq.size() < npix && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, wq.size() >= npix, 1);
    endtask

    task automatic check_frame(string tag, logic [11:0] mask);
        int  bad;
        int  n;
        wr_t w;
        bad = 0;
        n = wq.size();
        check({tag, "_count"}, n, NPX);
        for (int i = 0; i < n; i++) begin
            w = wq.pop_front();
            if (w.addr != i || w.data != exp_color(i % W, i / W, mask))
                bad++;
        end
        check({tag, "_bad_px"}, bad, 0);
    endtask

    logic [11:0] m_old;
    logic [11:0] m_new;
    int          d_a0;
    int          d_a7;
    int          dc;

    initial begin
        rst       = 1'b1;
        keys_down = '0;
        start     = 1'b0;
        fb_ready  = 1'b1;
        repeat (3) tick();
        check("rst_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_data, 0);
        check("rst_x", gfx_x, 0);
        check("rst_y", gfx_y, 0);
        check("rst_play", is_key_playing, 0);

        // 1: first frame after reset, full speed
        first_we_cyc = -1;
        rst = 1'b0;
        wait_frame("f1", 12000);
        check("f1_latency", done_cyc - first_we_cyc, 9239);
        check_frame("f1", 12'h000);
        repeat (40) tick();
        check("f1_idle_wr", wq.size(), 0);
        check("f1_idle_busy", busy, 0);

        // 2: key 0 pressed triggers a rescan
        keys_down = 12'h001;
        wait_frame("f2", 12000);
        d_a0 = (wq.size() > 0) ? wq[0].data : -1;
        d_a7 = (wq.size() > 7) ? wq[7].data : -1;
        check("f2_a0_red", d_a0, 4);
        check("f2_a7_blk", d_a7, 0);
        check_frame("f2", 12'h001);

        // 3: random mask, random backpressure
        m_old = 12'($urandom) | 12'h100;
        keys_down = m_old;
        rdy_rand = 1;
        wait_frame("f3", 40000);
        rdy_rand = 0;
        check("f3_stall", stall_bad, 0);
        check_frame("f3", m_old);

        // 4: mask change mid-frame is deferred to the next frame
        m_new = m_old ^ 12'h0A5;
        pulse_start();
        wait_pixels("f4", 2000, 20000);
        keys_down = m_new;
        wait_frame("f4a", 12000);
        check_frame("f4a", m_old);
        wait_frame("f4b", 12000);
        check_frame("f4b", m_new);

        // 5: repeated starts while busy yield one extra frame
        pulse_start();
        wait_pixels("f5", 100, 20000);
        pulse_start();
        repeat (7) tick();
        pulse_start();
        repeat (13) tick();
        pulse_start();
        wait_frame("f5a", 12000);
        check_frame("f5a", m_new);
        wait_frame("f5b", 12000);
        check_frame("f5b", m_new);
        dc = done_cnt;
        repeat (40) tick();
        check("f5_no_more", done_cnt - dc, 0);
        check("f5_idle_wr", wq.size(), 0);
        check("f5_idle_busy", busy, 0);

        // 6: reset mid-frame aborts and the scan restarts at 0
        pulse_start();
        wait_pixels("f6", 1000, 20000);
        rst = 1'b1;
        #1;
        check("f6_rst_we", fb_we, 0);
        check("f6_rst_busy", busy, 0);
        repeat (2) tick();
        wq.delete();
        rst = 1'b0;
        wait_frame("f6", 12000);
        check_frame("f6", m_new);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
